mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the 8-bit RISC processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables, and the 2-bit alu_op consumed by alu_control.
- Stalls on a memory ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26]-style opcode field from instruction register
mem_ready  input  1  memory completes current read/write this cycle
alu_op  output  2  00 add, 01 sub, 10 R-type (use fcode); to alu_control
alu_src_a  output  1  0 PC, 1 reg A
alu_src_b  output  2  00 reg B, 01 constant 1, 10 sign-ext imm
pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (gated in datapath)
iord  output  1  memory address: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 MDR
reg_write  output  1  register file write enable
retire  output  1  one-cycle pulse on instruction completion
instr_count  output  CNT_W  retired-instruction count
halted  output  1  high while in ILLEGAL
state  output  4  current state code, for debug

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state <= FETCH (0), instr_count <= 0. While rst is high, all control outputs, retire and halted are forced to 0.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, ILLEGAL 12. Codes 13–15 go to FETCH next cycle, with all outputs 0.
- Outputs are Moore decodes of state, except pc_write/ir_write in FETCH and retire in MEM_WR, which are also qualified by mem_ready. Unlisted outputs are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stay while !mem_ready, else go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute).
  - Next state by opcode: 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC; any other -> ILLEGAL.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - opcode 100011 -> MEM_RD, else MEM_WR.
- MEM_RD:
  - mem_read=1, iord=1.
  - Stay while !mem_ready, else go to MEM_WB.
- MEM_WB:
  - reg_write=1, mem_to_reg=1, reg_dst=0, retire=1.
  - Next FETCH.
- MEM_WR:
  - mem_write=1, iord=1, retire=mem_ready.
  - Stay while !mem_ready, else go to FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next R_WB.
- R_WB:
  - reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
  - Next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1.
  - Next FETCH.
- JUMP:
  - pc_write=1, pc_source=10, retire=1.
  - Next FETCH.
- ADDI_EXEC:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next ADDI_WB.
- ADDI_WB:
  - reg_write=1, reg_dst=0, mem_to_reg=0, retire=1.
  - Next FETCH.
- ILLEGAL: halted=1, all enables 0. Stays until rst.
- Cycle counts with mem_ready tied high: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle mem_ready is low in a memory state adds one cycle.
- instr_count increments in the cycle retire=1 (visible next cycle). It wraps from 2^CNT_W-1 to 0.
- mem_read and mem_write are never both high. reg_write never coincides with mem_write.
- Reset asserted mid-instruction (any state, including ILLEGAL) takes effect next edge. There is no partial retire: no retire pulse and no count increment in the reset cycle.
- opcode is sampled only in DECODE and MEM_ADDR. The IR must hold it stable from DECODE through MEM_ADDR.

Test Plan:
- Reset, then opcode=000000, mem_ready=1 -> state 0,1,6,7,0. alu_op=10 in R_EXEC. reg_write=1, reg_dst=1 in R_WB. retire pulse; instr_count=1.
- lw (100011) with mem_ready low 2 cycles in MEM_RD -> state 0,1,2,3,3,3,4,0. mem_read and iord=1 held in MEM_RD. mem_to_reg=1 in MEM_WB. Total 7 cycles.
- beq (000100) -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01, retire=1. j (000010) -> JUMP has pc_write=1, pc_source=10.
- FETCH with mem_ready=0 for 3 cycles -> ir_write and pc_write stay 0; both are 1 only in the mem_ready=1 cycle. mem_read is 1 throughout.
- opcode=111111 -> ILLEGAL after DECODE; halted=1 and state=12 persist 20 cycles. rst=1 for one cycle -> state=0, instr_count=0, halted=0.
- CNT_W=4: run 16 addi (001000) -> instr_count reads 15 then 0. rst asserted in ADDI_EXEC -> no retire, next state FETCH.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle main control FSM for the 8-bit RISC core
module mc_main_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = cur;

  always_comb begin
    nxt           = S_FETCH;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_RTYPE:     nxt = S_R_EXEC;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EXEC;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        nxt      = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        nxt       = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_ILLEGAL: begin
        halted = 1'b1;
        nxt    = S_ILLEGAL;
      end
      default: nxt = S_FETCH;
    endcase
    // Reset masks every output so a half-finished instruction never retires.
    if (rst) begin
      alu_op        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - table-driven bench for mc_main_ctrl with directed corner sequences
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, retire, halted;
  logic [3:0] instr_count;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retire(retire), .instr_count(instr_count), .halted(halted), .state(state)
  );

  // ctrl order: alu_op, alu_src_a, alu_src_b, pc_source, then
  // pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, retire, halted
  logic [17:0] ctrl;
  assign ctrl = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, retire, halted};

  localparam logic [17:0] C_ZERO    = 18'd0;
  localparam logic [17:0] C_FETCH_R = {2'b00, 1'b0, 2'b01, 2'b00, 11'b10010100000};
  localparam logic [17:0] C_FETCH_W = {2'b00, 1'b0, 2'b01, 2'b00, 11'b00010000000};
  localparam logic [17:0] C_DEC     = {2'b00, 1'b0, 2'b10, 2'b00, 11'b00000000000};
  localparam logic [17:0] C_MADDR   = {2'b00, 1'b1, 2'b10, 2'b00, 11'b00000000000};
  localparam logic [17:0] C_MRD     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00110000000};
  localparam logic [17:0] C_MWB     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000001110};
  localparam logic [17:0] C_MWR_R   = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00101000010};
  localparam logic [17:0] C_MWR_W   = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00101000000};
  localparam logic [17:0] C_REX     = {2'b10, 1'b1, 2'b00, 2'b00, 11'b00000000000};
  localparam logic [17:0] C_RWB     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000010110};
  localparam logic [17:0] C_BR      = {2'b01, 1'b1, 2'b00, 2'b01, 11'b01000000010};
  localparam logic [17:0] C_J       = {2'b00, 1'b0, 2'b00, 2'b10, 11'b10000000010};
  localparam logic [17:0] C_AEX     = {2'b00, 1'b1, 2'b10, 2'b00, 11'b00000000000};
  localparam logic [17:0] C_AWB     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000000110};
  localparam logic [17:0] C_ILL     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000000001};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctrl;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[33];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_addi();
    opcode = ADDI; mem_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, R,    1'b1, 4'd0,  C_ZERO,    4'd0};
    vecs[1]  = '{1'b0, R,    1'b1, 4'd0,  C_FETCH_R, 4'd0};
    vecs[2]  = '{1'b0, R,    1'b1, 4'd1,  C_DEC,     4'd0};
    vecs[3]  = '{1'b0, R,    1'b1, 4'd6,  C_REX,     4'd0};
    vecs[4]  = '{1'b0, R,    1'b1, 4'd7,  C_RWB,     4'd0};
    vecs[5]  = '{1'b0, LW,   1'b1, 4'd0,  C_FETCH_R, 4'd1};
    vecs[6]  = '{1'b0, LW,   1'b1, 4'd1,  C_DEC,     4'd1};
    vecs[7]  = '{1'b0, LW,   1'b1, 4'd2,  C_MADDR,   4'd1};
    vecs[8]  = '{1'b0, LW,   1'b0, 4'd3,  C_MRD,     4'd1};
    vecs[9]  = '{1'b0, LW,   1'b0, 4'd3,  C_MRD,     4'd1};
    vecs[10] = '{1'b0, LW,   1'b1, 4'd3,  C_MRD,     4'd1};
    vecs[11] = '{1'b0, LW,   1'b1, 4'd4,  C_MWB,     4'd1};
    vecs[12] = '{1'b0, SW,   1'b1, 4'd0,  C_FETCH_R, 4'd2};
    vecs[13] = '{1'b0, SW,   1'b1, 4'd1,  C_DEC,     4'd2};
    vecs[14] = '{1'b0, SW,   1'b1, 4'd2,  C_MADDR,   4'd2};
    vecs[15] = '{1'b0, SW,   1'b0, 4'd5,  C_MWR_W,   4'd2};
    vecs[16] = '{1'b0, SW,   1'b1, 4'd5,  C_MWR_R,   4'd2};
    vecs[17] = '{1'b0, BEQ,  1'b1, 4'd0,  C_FETCH_R, 4'd3};
    vecs[18] = '{1'b0, BEQ,  1'b1, 4'd1,  C_DEC,     4'd3};
    vecs[19] = '{1'b0, BEQ,  1'b1, 4'd8,  C_BR,      4'd3};
    vecs[20] = '{1'b0, J,    1'b1, 4'd0,  C_FETCH_R, 4'd4};
    vecs[21] = '{1'b0, J,    1'b1, 4'd1,  C_DEC,     4'd4};
    vecs[22] = '{1'b0, J,    1'b1, 4'd9,  C_J,       4'd4};
    vecs[23] = '{1'b0, ADDI, 1'b0, 4'd0,  C_FETCH_W, 4'd5};
    vecs[24] = '{1'b0, ADDI, 1'b0, 4'd0,  C_FETCH_W, 4'd5};
    vecs[25] = '{1'b0, ADDI, 1'b0, 4'd0,  C_FETCH_W, 4'd5};
    vecs[26] = '{1'b0, ADDI, 1'b1, 4'd0,  C_FETCH_R, 4'd5};
    vecs[27] = '{1'b0, ADDI, 1'b1, 4'd1,  C_DEC,     4'd5};
    vecs[28] = '{1'b0, ADDI, 1'b1, 4'd10, C_AEX,     4'd5};
    vecs[29] = '{1'b0, ADDI, 1'b1, 4'd11, C_AWB,     4'd5};
    vecs[30] = '{1'b0, BAD,  1'b1, 4'd0,  C_FETCH_R, 4'd6};
    vecs[31] = '{1'b0, BAD,  1'b1, 4'd1,  C_DEC,     4'd6};
    vecs[32] = '{1'b0, BAD,  1'b1, 4'd12, C_ILL,     4'd6};

    rst = 1'b1; opcode = R; mem_ready = 1'b1;
    tick();

    for (int i = 0; i < 33; i++) begin
      rst = vecs[i].rst; opcode = vecs[i].opcode; mem_ready = vecs[i].mem_ready;
      #1;
      chk("state", i, 32'(state), 32'(vecs[i].exp_state));
      chk("ctrl", i, 32'(ctrl), 32'(vecs[i].exp_ctrl));
      chk("count", i, 32'(instr_count), 32'(vecs[i].exp_cnt));
      chk("rd_wr_excl", i, 32'(mem_read & mem_write), 32'd0);
      tick();
    end

    // ILLEGAL must hold regardless of inputs until reset
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; opcode = R;
      #1;
      chk("ill_state", i, 32'(state), 32'd12);
      chk("ill_halted", i, 32'(halted), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("ill_rst_halted", 0, 32'(halted), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_state", 0, 32'(state), 32'd0);
    chk("post_rst_count", 0, 32'(instr_count), 32'd0);
    chk("post_rst_halted", 0, 32'(halted), 32'd0);

    // counter wrap at CNT_W=4
    for (int i = 0; i < 16; i++) begin
      run_addi();
      chk("wrap_count", i, 32'(instr_count), 32'((i + 1) % 16));
    end

    // reset during ADDI_EXEC
    opcode = ADDI; mem_ready = 1'b1;
    tick(); tick();
    chk("aex_state", 0, 32'(state), 32'd10);
    rst = 1'b1;
    #1;
    chk("aex_rst_retire", 0, 32'(retire), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("aex_rst_state", 0, 32'(state), 32'd0);
    chk("aex_rst_count", 0, 32'(instr_count), 32'd0);

    // reset during ADDI_WB: retire masked, no increment
    tick(); tick(); tick();
    chk("awb_state", 0, 32'(state), 32'd11);
    rst = 1'b1;
    #1;
    chk("awb_rst_retire", 0, 32'(retire), 32'd0);
    chk("awb_rst_regwrite", 0, 32'(reg_write), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("awb_rst_state", 0, 32'(state), 32'd0);
    chk("awb_rst_count", 0, 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
